// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: {cout,sum} = a + b + cin, one full-add step per clock, LSB first.
// Three-state controller with valid/ready handshakes on both sides and a synchronous abort.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  // state | meaning
  // IDLE  | waiting for an operation, in_ready high
  // RUN   | one result bit per clock, busy high
  // DONE  | result held, out_valid high until consumed
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;

  logic ha1_s, ha1_c, ha2_s, ha2_c, fa_c;

  // Full adder as two cascaded half adders.
  always_comb begin
    ha1_s = a_q[0] ^ b_q[0];
    ha1_c = a_q[0] & b_q[0];
    ha2_s = ha1_s ^ carry_q;
    ha2_c = ha1_s & carry_q;
    fa_c  = ha1_c | ha2_c;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = RUN;
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          a_d     = '0;
          b_d     = '0;
          sum_d   = '0;
          cnt_d   = '0;
          carry_d = 1'b0;
          cout_d  = 1'b0;
        end else begin
          sum_d[cnt_q] = ha2_s;
          carry_d      = fa_c;
          a_d          = a_q >> 1;
          b_d          = b_q >> 1;
          // Counter parks on the last index instead of wrapping.
          if (cnt_q == LAST) begin
            state_d = DONE;
            cout_d  = fa_c;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl with a queue of expected results.
module tb_serial_add_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready;
  logic [7:0] a, b;
  logic       cin, abort;
  logic       out_valid, out_ready;
  logic [7:0] sum;
  logic       cout, busy;

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];

  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .abort(abort), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic accept(input logic [7:0] av, input logic [7:0] bv, input logic c, input bit push);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", 32'(in_ready), 32'd1);
    a = av; b = bv; cin = c; in_valid = 1'b1;
    if (push) exp_q.push_back({1'b0, av} + {1'b0, bv} + {8'd0, c});
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_result(input int lat0);
    int lat = lat0;
    logic [8:0] e;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'd8);
    if (exp_q.size() == 0) begin
      chk("scoreboard_nonempty", 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk("sum", 32'(sum), 32'(e[7:0]));
      chk("cout", 32'(cout), 32'(e[8]));
    end
  endtask

  task automatic run_op(input logic [7:0] av, input logic [7:0] bv, input logic c);
    accept(av, bv, c, 1'b1);
    wait_result(0);
    @(posedge clk);
    #1 chk("idle_after_handshake", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int ov_seen;
    logic [8:0] held;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
    abort = 1'b0; out_ready = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    run_op(8'h00, 8'h00, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0);
    run_op(8'hA5, 8'h5A, 1'b1);
    run_op(8'h80, 8'h80, 1'b1);

    // Consumer stalls for 5 clocks; result must be held.
    out_ready = 1'b0;
    accept(8'h3C, 8'h42, 1'b0, 1'b1);
    held = exp_q[0];
    wait_result(0);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_sum", 32'(sum), 32'(held[7:0]));
      chk("stall_cout", 32'(cout), 32'(held[8]));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("stall_release_idle", 32'(in_ready), 32'd1);
    chk("stall_release_valid", 32'(out_valid), 32'd0);

    // New request and operand changes during RUN must be ignored.
    accept(8'h12, 8'h34, 1'b0, 1'b1);
    in_valid = 1'b1; a = 8'hFF; b = 8'hFF;
    chk("run_not_ready", 32'(in_ready), 32'd0);
    chk("run_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      #1;
      a = 8'(i * 37 + 1);
      b = ~a;
      cin = ~cin;
    end
    wait_result(7);
    @(posedge clk);
    #1;
    chk("ignored_op_not_taken", 32'(in_ready), 32'd1);
    in_valid = 1'b0; cin = 1'b0;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    // Abort on the 4th RUN clock.
    accept(8'h55, 8'h33, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    chk("abort_idle", 32'(in_ready), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    ov_seen = 0;
    repeat (12) begin
      @(posedge clk);
      #1 if (out_valid) ov_seen++;
    end
    chk("abort_no_out_valid", 32'(ov_seen), 32'd0);

    // Asynchronous reset mid-RUN with partial sum already written.
    accept(8'h0F, 8'h00, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_sum", 32'(sum), 32'd0);
    chk("arst_cout", 32'(cout), 32'd0);
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    ov_seen = 0;
    repeat (12) begin
      @(posedge clk);
      #1 if (out_valid) ov_seen++;
    end
    chk("arst_no_out_valid", 32'(ov_seen), 32'd0);

    run_op(8'hC3, 8'h7E, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
